// File: rtl/user_clk_tick_gen.sv
// Samples a divided user clock and its reset as data in the CLK_IN domain.
// Produces a per-edge tick, a tick timestamp, a periodic trigger and a clock-loss flag.
module user_clk_tick_gen #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT     = 100
) (
    input  logic             CLK_IN,
    input  logic             RST_IN,
    input  logic             USER_CLK_IN,
    input  logic             USER_RST_IN,
    input  logic             EN_IN,
    input  logic [15:0]      TRIG_PERIOD_IN,
    input  logic [7:0]       TRIG_WIDTH_IN,
    output logic             TICK_OUT,
    output logic [CNT_W-1:0] TSTAMP_OUT,
    output logic             TRIG_OUT,
    output logic             CLK_LOSS_OUT
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [SYNC_STAGES-1:0] uclk_sync_q;
    logic [SYNC_STAGES-1:0] urst_sync_q;
    logic                   uclk_d_q;
    logic                   tick_q;
    logic [CNT_W-1:0]       tstamp_q;
    logic [15:0]            phase_q;
    logic                   trig_q;
    logic [7:0]             width_q;
    logic [WD_W-1:0]        wd_q;
    logic                   loss_q;

    logic        uclk_s;
    logic        urst_s;
    logic        tick_d;
    logic        fire;
    logic [15:0] period_m1;
    logic [7:0]  width_m1;

    always_comb begin
        uclk_s    = uclk_sync_q[SYNC_STAGES-1];
        urst_s    = urst_sync_q[SYNC_STAGES-1];
        // User reset masks a rise seen in the same cycle.
        tick_d    = uclk_s & ~uclk_d_q & ~urst_s;
        period_m1 = (TRIG_PERIOD_IN == 16'd0) ? 16'd0 : TRIG_PERIOD_IN - 16'd1;
        width_m1  = (TRIG_WIDTH_IN == 8'd0) ? 8'd0 : TRIG_WIDTH_IN - 8'd1;
        fire      = tick_d & EN_IN & (phase_q == 16'd0);
    end

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            uclk_sync_q <= '0;
            urst_sync_q <= '0;
            uclk_d_q    <= 1'b0;
            tick_q      <= 1'b0;
            tstamp_q    <= '0;
            phase_q     <= '0;
            trig_q      <= 1'b0;
            width_q     <= '0;
            wd_q        <= '0;
            loss_q      <= 1'b0;
        end else begin
            uclk_sync_q <= {uclk_sync_q[SYNC_STAGES-2:0], USER_CLK_IN};
            urst_sync_q <= {urst_sync_q[SYNC_STAGES-2:0], USER_RST_IN};
            uclk_d_q    <= uclk_s;
            tick_q      <= tick_d;
            if (urst_s) begin
                tstamp_q <= '0;
                phase_q  <= '0;
                trig_q   <= 1'b0;
                width_q  <= '0;
                wd_q     <= '0;
                loss_q   <= 1'b0;
            end else begin
                tstamp_q <= tstamp_q + {{(CNT_W-1){1'b0}}, tick_q};
                if (!EN_IN) begin
                    phase_q <= '0;
                    trig_q  <= 1'b0;
                    width_q <= '0;
                end else begin
                    // >= so a shrinking period wraps at once instead of overrunning.
                    if (tick_d) begin
                        phase_q <= (phase_q >= period_m1) ? 16'd0 : phase_q + 16'd1;
                    end
                    // width_q holds the remaining high cycles after the current one.
                    if (fire) begin
                        trig_q  <= 1'b1;
                        width_q <= width_m1;
                    end else if (trig_q) begin
                        if (width_q == 8'd0) begin
                            trig_q <= 1'b0;
                        end else begin
                            width_q <= width_q - 8'd1;
                        end
                    end
                end
                if (tick_d) begin
                    wd_q   <= '0;
                    loss_q <= 1'b0;
                end else begin
                    if (wd_q != WD_W'(TIMEOUT)) begin
                        wd_q <= wd_q + 1'b1;
                    end
                    loss_q <= (wd_q >= WD_W'(TIMEOUT - 1));
                end
            end
        end
    end

    assign TICK_OUT     = tick_q;
    assign TSTAMP_OUT   = tstamp_q;
    assign TRIG_OUT     = trig_q;
    assign CLK_LOSS_OUT = loss_q;

endmodule
